// File: rtl/stage_controller.sv
// Game-flow sequencer: TITLE/STAFF menus, three timed stages with hearts, key and door,
// fixed-length success screens between stages, and a FAIL screen on heart loss or timeout.
module stage_controller #(
  parameter int unsigned SUCCESS_FRAMES = 120,
  parameter int unsigned INVULN_FRAMES  = 60,
  parameter int unsigned STAGE_FRAMES   = 3600,
  parameter int unsigned MAX_HEART      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        staff,
  input  logic        key_pick,
  input  logic        door_enter,
  input  logic        hit,
  output logic [3:0]  state,
  output logic [2:0]  heart,
  output logic        key_find,
  output logic        isLocked,
  output logic        play_valid,
  output logic [11:0] time_left
);

  typedef enum logic [3:0] {
    TITLE    = 4'd0,
    STAFF    = 4'd1,
    STAGE1   = 4'd2,
    SUCCESS1 = 4'd3,
    STAGE2   = 4'd4,
    SUCCESS2 = 4'd5,
    STAGE3   = 4'd6,
    SUCCESS3 = 4'd7,
    FAIL     = 4'd8
  } state_e;

  localparam logic [11:0] HOLD_INIT   = 12'(SUCCESS_FRAMES);
  localparam logic [11:0] INVULN_INIT = 12'(INVULN_FRAMES);
  localparam logic [11:0] STAGE_INIT  = 12'(STAGE_FRAMES);
  localparam logic [2:0]  HEART_INIT  = 3'(MAX_HEART);

  state_e      state_q, state_d;
  logic [2:0]  heart_q, heart_d;
  logic        key_find_q, key_find_d;
  logic        play_valid_q, play_valid_d;
  logic [11:0] time_left_q, time_left_d;
  logic [11:0] hold_q, hold_d;
  logic [11:0] invuln_q, invuln_d;

  logic [11:0] invuln_dec;
  logic        exit_ok;
  logic        hit_ok;
  logic        timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= TITLE;
      heart_q      <= '0;
      key_find_q   <= 1'b0;
      play_valid_q <= 1'b0;
      time_left_q  <= '0;
      hold_q       <= '0;
      invuln_q     <= '0;
    end else begin
      state_q      <= state_d;
      heart_q      <= heart_d;
      key_find_q   <= key_find_d;
      play_valid_q <= play_valid_d;
      time_left_q  <= time_left_d;
      hold_q       <= hold_d;
      invuln_q     <= invuln_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    heart_d     = heart_q;
    key_find_d  = key_find_q;
    time_left_d = time_left_q;
    hold_d      = hold_q;
    invuln_d    = invuln_q;

    // A hit is judged against the immunity left after this cycle's tick, so a hit
    // coinciding with the tick that expires immunity is taken.
    invuln_dec = (frame_tick && invuln_q != '0) ? invuln_q - 12'd1 : invuln_q;
    exit_ok    = door_enter & key_find_q;
    hit_ok     = hit & (invuln_dec == '0) & (heart_q != '0);
    timeout    = frame_tick & (time_left_q == 12'd1);

    case (state_q)
      TITLE: begin
        if (start) begin
          state_d     = STAGE1;
          heart_d     = HEART_INIT;
          key_find_d  = 1'b0;
          time_left_d = STAGE_INIT;
          invuln_d    = '0;
        end else if (staff) begin
          state_d = STAFF;
        end
      end
      STAFF: begin
        if (start || staff) state_d = TITLE;
      end
      STAGE1, STAGE2, STAGE3: begin
        key_find_d = key_find_q | key_pick;
        invuln_d   = invuln_dec;
        if (exit_ok) begin
          state_d = (state_q == STAGE1) ? SUCCESS1 :
                    (state_q == STAGE2) ? SUCCESS2 : SUCCESS3;
          hold_d  = HOLD_INIT;
        end else begin
          if (frame_tick && time_left_q != '0) time_left_d = time_left_q - 12'd1;
          if (hit_ok) begin
            heart_d  = heart_q - 3'd1;
            invuln_d = INVULN_INIT;
          end
          if ((hit_ok && heart_q == 3'd1) || timeout) state_d = FAIL;
        end
      end
      SUCCESS1, SUCCESS2: begin
        if (frame_tick) begin
          hold_d = hold_q - 12'd1;
          if (hold_q == 12'd1) begin
            state_d     = (state_q == SUCCESS1) ? STAGE2 : STAGE3;
            key_find_d  = 1'b0;
            time_left_d = STAGE_INIT;
            invuln_d    = '0;
          end
        end
      end
      SUCCESS3, FAIL: begin
        if (start) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase

    play_valid_d = (state_d == STAGE1) || (state_d == STAGE2) || (state_d == STAGE3);
  end

  assign state      = state_q;
  assign heart      = heart_q;
  assign key_find   = key_find_q;
  assign isLocked   = ~key_find_q;
  assign play_valid = play_valid_q;
  assign time_left  = time_left_q;

endmodule
